// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the bit-capture stage: valid/ready word input,
// one bit per clock out, with a one-word hold buffer so words stream gap-free.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IN_WORD,
    input  logic             in_word_valid,
    output logic             IN_WORD_READY,
    output logic             OUT_DATA,
    output logic             out_valid,
    output logic             OUT_TMP,
    output logic [CNT_W-1:0] WORD_CNT
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;

    logic shift_busy;
    logic last_bit;
    logic done;
    logic accept;

    assign shift_busy    = (state == SHIFT);
    assign last_bit      = (bit_cnt == LAST_BIT);
    assign done          = !shift_busy || last_bit;
    assign IN_WORD_READY = !hold_valid && rst_n;
    assign accept        = in_word_valid && IN_WORD_READY;

    assign out_valid = shift_busy;
    assign OUT_TMP   = shift_busy && last_bit;
    assign OUT_DATA  = shift_busy && (MSB_FIRST ? shifter[WIDTH-1] : shifter[0]);

    // Control state: a finishing word reloads from hold first, then from the
    // input, so an accepted word never has to wait behind an empty shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            hold_valid <= 1'b0;
            WORD_CNT   <= '0;
        end else begin
            if (OUT_TMP)
                WORD_CNT <= WORD_CNT + 1'b1;
            if (done) begin
                if (hold_valid) begin
                    state      <= SHIFT;
                    bit_cnt    <= '0;
                    hold_valid <= 1'b0;
                end else if (accept) begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                end else begin
                    state <= IDLE;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                if (accept)
                    hold_valid <= 1'b1;
            end
        end
    end

    // Datapath: contents are qualified by shift_busy/hold_valid, so no reset.
    always_ff @(posedge clk) begin
        if (done) begin
            if (hold_valid)
                shifter <= hold;
            else if (accept)
                shifter <= IN_WORD;
        end else if (MSB_FIRST) begin
            shifter <= {shifter[WIDTH-2:0], 1'b0};
        end else begin
            shifter <= {1'b0, shifter[WIDTH-1:1]};
        end
        if (!done && accept)
            hold <= IN_WORD;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first/16-bit-count instance and an
// LSB-first/4-bit-count instance share stimulus; a bit-queue model checks both.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_word = 8'h00;
    logic       in_valid = 1'b0;

    logic        rdy_a, data_a, vld_a, tmp_a;
    logic [15:0] cnt_a;
    logic        rdy_b, data_b, vld_b, tmp_b;
    logic [3:0]  cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int seen_vld_a = 0;
    int seen_tmp_a = 0;

    // Each entry is {last_bit_of_word, data_bit}, in emission order.
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    int         mcnt_a = 0;
    int         mcnt_b = 0;

    logic [7:0] cap;
    logic [7:0] tcap;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .IN_WORD(in_word), .in_word_valid(in_valid),
        .IN_WORD_READY(rdy_a), .OUT_DATA(data_a), .out_valid(vld_a),
        .OUT_TMP(tmp_a), .WORD_CNT(cnt_a)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .IN_WORD(in_word), .in_word_valid(in_valid),
        .IN_WORD_READY(rdy_b), .OUT_DATA(data_b), .out_valid(vld_b),
        .OUT_TMP(tmp_b), .WORD_CNT(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Words not yet fully emitted; the block can take another while at most one is pending.
    function automatic int words_in_flight();
        int n = 0;
        foreach (qa[i]) if (qa[i][1]) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        return rst_n && (words_in_flight() < 2);
    endfunction

    // Model: accepted words append their bits to a stream, one bit leaves per clock.
    initial begin
        bit rdy;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                qa.delete();
                qb.delete();
                mcnt_a = 0;
                mcnt_b = 0;
            end else begin
                rdy = m_ready();
                if (qa.size() > 0) begin
                    if (qa[0][1]) mcnt_a = (mcnt_a + 1) % 65536;
                    void'(qa.pop_front());
                end
                if (qb.size() > 0) begin
                    if (qb[0][1]) mcnt_b = (mcnt_b + 1) % 16;
                    void'(qb.pop_front());
                end
                if (in_valid && rdy) begin
                    for (int i = 0; i < 8; i++) begin
                        qa.push_back({i == 7, in_word[7-i]});
                        qb.push_back({i == 7, in_word[i]});
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("a_valid", vld_a, qa.size() > 0);
            check("a_data", data_a, (qa.size() > 0) ? qa[0][0] : 1'b0);
            check("a_tmp", tmp_a, (qa.size() > 0) ? qa[0][1] : 1'b0);
            check("a_cnt", cnt_a, mcnt_a);
            check("a_ready", rdy_a, m_ready());
            check("b_valid", vld_b, qb.size() > 0);
            check("b_data", data_b, (qb.size() > 0) ? qb[0][0] : 1'b0);
            check("b_tmp", tmp_b, (qb.size() > 0) ? qb[0][1] : 1'b0);
            check("b_cnt", cnt_b, mcnt_b);
            check("b_ready", rdy_b, m_ready());
            if (vld_a) seen_vld_a++;
            if (tmp_a) seen_tmp_a++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen_vld_a = 0;
        seen_tmp_a = 0;
    endtask

    // Present a word and hold valid until the edge that accepts it.
    task automatic offer(input logic [7:0] w);
        bit acc;
        in_word = w;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            acc = m_ready();
            step();
            if (acc) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL offer_timeout: word %0h not accepted, expected within 64 cycles", w);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single MSB-first word
        seen_vld_a = 0;
        seen_tmp_a = 0;
        offer(8'hA5);
        in_valid = 1'b0;
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cap = {cap[6:0], data_a};
        end
        check("t1_bits", cap, 8'hA5);
        @(negedge clk);
        check("t1_valid_after", vld_a, 1'b0);
        check("t1_cnt", cnt_a, 16'd1);
        step();
        check("t1_valid_cycles", seen_vld_a, 8);
        check("t1_tmp_cycles", seen_tmp_a, 1);

        // Back-to-back words
        do_reset();
        offer(8'hFF);
        offer(8'h00);
        check("t2_ready_held", rdy_a, 1'b0);
        offer(8'h3C);
        in_valid = 1'b0;
        repeat (30) step();
        check("t2_cnt", cnt_a, 16'd3);
        check("t2_valid_cycles", seen_vld_a, 24);
        check("t2_tmp_cycles", seen_tmp_a, 3);

        // LSB-first word
        do_reset();
        offer(8'h01);
        in_valid = 1'b0;
        cap = '0;
        tcap = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cap = {cap[6:0], data_b};
            tcap = {tcap[6:0], tmp_b};
        end
        check("t3_bits", cap, 8'h80);
        check("t3_tmp", tcap, 8'h01);

        // Asynchronous reset with a word in hold
        do_reset();
        offer(8'hA5);
        offer(8'h5A);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t4_valid", vld_a, 1'b0);
        check("t4_tmp", tmp_a, 1'b0);
        check("t4_data", data_a, 1'b0);
        check("t4_cnt", cnt_a, 16'd0);
        check("t4_ready", rdy_a, 1'b0);
        check("t4_valid_b", vld_b, 1'b0);
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        seen_vld_a = 0;
        repeat (8) step();
        check("t4_idle_after", seen_vld_a, 0);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int k = 1; k <= 17; k++) offer(8'(k * 13));
        check("t5_cnt15_b", cnt_b, 4'd15);
        check("t5_cnt15_a", cnt_a, 16'd15);
        in_valid = 1'b0;
        repeat (8) step();
        check("t5_cnt16_b", cnt_b, 4'd0);
        repeat (8) step();
        check("t5_cnt17_b", cnt_b, 4'd1);
        check("t5_cnt17_a", cnt_a, 16'd17);

        // Words separated by an input gap
        do_reset();
        offer(8'hC3);
        in_valid = 1'b0;
        repeat (10) step();
        offer(8'h81);
        in_valid = 1'b0;
        repeat (20) step();
        check("t6_valid_cycles", seen_vld_a, 16);
        check("t6_tmp_cycles", seen_tmp_a, 2);
        check("t6_cnt", cnt_a, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
